// File: rtl/noc_input_port.sv
// Per-direction NoC router input unit: single-flit packet FIFO with XY route
// computation on the head flit, presented as a request code to the switch arbiter.
module noc_input_port #(
    parameter int unsigned FLIT_WIDTH = 16,
    parameter int unsigned ADDR_W     = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CUR_X      = 0,
    parameter int unsigned CUR_Y      = 0,
    parameter int unsigned N_REGISTER = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [FLIT_WIDTH-1:0] data_in,
    output logic                  full,
    output logic                  empty,
    output logic [N_REGISTER-1:0] request,
    input  logic                  grant,
    output logic [FLIT_WIDTH-1:0] data_out
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0]     CUR_X_C  = ADDR_W'(CUR_X);
    localparam logic [ADDR_W-1:0]     CUR_Y_C  = ADDR_W'(CUR_Y);
    localparam logic [N_REGISTER-1:0] REQ_L    = N_REGISTER'(0);
    localparam logic [N_REGISTER-1:0] REQ_E    = N_REGISTER'(1);
    localparam logic [N_REGISTER-1:0] REQ_W    = N_REGISTER'(2);
    localparam logic [N_REGISTER-1:0] REQ_N    = N_REGISTER'(3);
    localparam logic [N_REGISTER-1:0] REQ_S    = N_REGISTER'(4);
    localparam logic [N_REGISTER-1:0] REQ_IDLE = N_REGISTER'(7);

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;
    logic [FLIT_WIDTH-1:0] head;
    logic [ADDR_W-1:0]     dx;
    logic [ADDR_W-1:0]     dy;

    // full/empty come straight from the registered occupancy
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign push  = valid_in && !full;
    assign pop   = grant && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Buffer storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    assign head     = mem[rd_ptr];
    assign dx       = head[FLIT_WIDTH-1 -: ADDR_W];
    assign dy       = head[FLIT_WIDTH-1-ADDR_W -: ADDR_W];
    assign data_out = empty ? '0 : head;

    // XY dimension-order routing: resolve X first, then Y
    always_comb begin
        request = REQ_IDLE;
        if (!empty) begin
            if (dx > CUR_X_C)
                request = REQ_E;
            else if (dx < CUR_X_C)
                request = REQ_W;
            else if (dy > CUR_Y_C)
                request = REQ_N;
            else if (dy < CUR_Y_C)
                request = REQ_S;
            else
                request = REQ_L;
        end
    end

endmodule

// File: tb/tb_noc_input_port.sv
// Bench for noc_input_port at router (1,1): directed scenarios plus random
// traffic, checked against a queue-based model of the input buffer.
module tb_noc_input_port;

    localparam int unsigned FW    = 16;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CX    = 1;
    localparam int unsigned CY    = 1;
    localparam int unsigned NR    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [FW-1:0] data_in;
    logic          full;
    logic          empty;
    logic [NR-1:0] request;
    logic          grant;
    logic [FW-1:0] data_out;

    int errors = 0;
    int checks = 0;
    logic [FW-1:0] q[$];

    noc_input_port #(
        .FLIT_WIDTH(FW), .ADDR_W(AW), .DEPTH(DEPTH),
        .CUR_X(CX), .CUR_Y(CY), .N_REGISTER(NR)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .full(full), .empty(empty), .request(request),
        .grant(grant), .data_out(data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(int x, int y);
        logic [FW-1:0] f;
        f = FW'($urandom);
        f[15:14] = 2'(x);
        f[13:12] = 2'(y);
        return f;
    endfunction

    // Route code from destination coordinates, by the XY rule
    function automatic logic [2:0] route_of(logic [FW-1:0] f);
        int dx;
        int dy;
        dx = int'(f[15:14]);
        dy = int'(f[13:12]);
        if (dx > int'(CX)) return 3'b001;
        if (dx < int'(CX)) return 3'b010;
        if (dy > int'(CY)) return 3'b011;
        if (dy < int'(CY)) return 3'b100;
        return 3'b000;
    endfunction

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [2:0]    er;
        logic [FW-1:0] ed;
        er = (q.size() == 0) ? 3'b111 : route_of(q[0]);
        ed = (q.size() == 0) ? '0 : q[0];
        cmp({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
        cmp({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
        cmp({tag, ".request"},  32'(request),  32'(er));
        cmp({tag, ".data_out"}, 32'(data_out), 32'(ed));
    endtask

    // One clock: drive, update model from pre-edge occupancy, sample 1ns later
    task automatic step(string tag, logic v, logic [FW-1:0] d, logic g);
        bit push_ok;
        bit pop_ok;
        valid_in = v;
        data_in  = d;
        grant    = g;
        push_ok  = v && (q.size() < DEPTH);
        pop_ok   = g && (q.size() > 0);
        @(posedge clk);
        if (pop_ok)  void'(q.pop_front());
        if (push_ok) q.push_back(d);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [2:0] route_seq [6];
        int         maxocc;
        route_seq = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b111};
        rst = 1'b1;
        valid_in = 1'b0;
        data_in = '0;
        grant = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Routing sequence
        step("rt_push", 1'b1, mk(2, 0), 1'b0);
        step("rt_push", 1'b1, mk(0, 3), 1'b0);
        step("rt_push", 1'b1, mk(1, 3), 1'b0);
        step("rt_push", 1'b1, mk(1, 0), 1'b0);
        for (int i = 0; i < 4; i++) begin
            cmp("route_seq", 32'(request), 32'(route_seq[i]));
            step("rt_pop", 1'b0, '0, 1'b1);
        end
        step("rt_push", 1'b1, mk(1, 1), 1'b0);
        cmp("route_seq", 32'(request), 32'(route_seq[4]));
        step("rt_pop", 1'b0, '0, 1'b1);
        cmp("route_seq", 32'(request), 32'(route_seq[5]));

        // Fill and overflow
        for (int i = 0; i < 5; i++)
            step("fill", 1'b1, mk(int'($urandom_range(3)), int'($urandom_range(3))), 1'b0);
        cmp("fill.full_after", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++)
            step("drain", 1'b0, '0, 1'b1);
        cmp("drain.empty_after", 32'(empty), 32'd1);

        // Simultaneous push/pop at count 2, at full, at empty
        step("sim2", 1'b1, mk(3, 3), 1'b0);
        step("sim2", 1'b1, mk(0, 0), 1'b0);
        step("sim2.pp", 1'b1, mk(2, 2), 1'b1);
        cmp("sim2.size", 32'(q.size()), 32'd2);
        step("simf", 1'b1, mk(1, 2), 1'b0);
        step("simf", 1'b1, mk(0, 1), 1'b0);
        step("simf.pp", 1'b1, mk(3, 0), 1'b1);
        cmp("simf.full", 32'(full), 32'd0);
        for (int i = 0; i < 3; i++)
            step("simf.drain", 1'b0, '0, 1'b1);
        step("sime.pp", 1'b1, mk(2, 3), 1'b1);
        cmp("sime.empty", 32'(empty), 32'd0);
        step("sime.drain", 1'b0, '0, 1'b1);

        // Streaming through the wrap point
        maxocc = 0;
        for (int i = 0; i < 10; i++) begin
            step("stream", 1'b1, mk(int'($urandom_range(3)), int'($urandom_range(3))), 1'b1);
            if (q.size() > maxocc) maxocc = q.size();
        end
        cmp("stream.maxocc", 32'(maxocc), 32'd1);
        step("stream.end", 1'b0, '0, 1'b1);

        // Grant while empty
        for (int i = 0; i < 3; i++)
            step("gempty", 1'b0, '0, 1'b1);
        step("gempty.push", 1'b1, mk(1, 1), 1'b0);
        step("gempty.pop", 1'b0, '0, 1'b1);

        // Reset mid-cycle with 3 flits held
        for (int i = 0; i < 3; i++)
            step("prerst", 1'b1, mk(int'($urandom_range(3)), int'($urandom_range(3))), 1'b0);
        valid_in = 1'b0;
        grant = 1'b0;
        #3;
        rst = 1'b1;
        q.delete();
        #1;
        check_all("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("postrst", 1'b1, mk(0, 2), 1'b0);
        step("postrst", 1'b1, mk(3, 1), 1'b1);
        step("postrst", 1'b0, '0, 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom), FW'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_input_port.md
# noc_input_port

Per-direction input unit of the 5-port NoC router: buffers single-flit packets arriving from one neighbour (or the local core), computes the XY output direction for the head flit, and presents it as a 3-bit request to the switch arbiter. One instance per port (L, N, E, S, W). Grant from the arbiter pops the head flit toward the crossbar; `full` goes back to the upstream router's arbiter.

## Interface
- `FLIT_WIDTH`, 16: flit width; bits [FLIT_WIDTH-1 -: ADDR_W] = dest X, next ADDR_W bits below = dest Y, rest payload.
- `ADDR_W`, 2: width of each destination coordinate.
- `DEPTH`, 4: FIFO depth in flits; power of two, >= 2.
- `CUR_X`, 0: this router's X coordinate.
- `CUR_Y`, 0: this router's Y coordinate.
- `N_REGISTER`, 3: request code width.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  upstream flit present on `data_in`.
- `data_in`  in  FLIT_WIDTH  incoming flit.
- `full`  out  1  FIFO holds DEPTH flits; upstream must not push.
- `empty`  out  1  FIFO holds 0 flits.
- `request`  out  N_REGISTER  output direction of head flit: 000 L, 001 E, 010 W, 011 N, 100 S, 111 idle.
- `grant`  in  1  arbiter grant; pop head flit this cycle.
- `data_out`  out  FLIT_WIDTH  head flit to crossbar; 0 when empty.

## Operation
- Storage: circular buffer of DEPTH entries, write pointer, read pointer (log2(DEPTH) bits, natural wrap), occupancy counter `count` (log2(DEPTH)+1 bits, range 0..DEPTH).
- Push: `valid_in && !full` writes `data_in` at write pointer, increments write pointer. `valid_in` while full: flit dropped, no state change.
- Pop: `grant && !empty` increments read pointer. `grant` while empty: ignored.
- Simultaneous push and pop (both legal): both pointers advance, `count` unchanged. Push while full is rejected even if a pop occurs the same cycle (full is evaluated on pre-edge state). Pop while empty is ignored even if a push occurs the same cycle.
- `full` = (count == DEPTH), `empty` = (count == 0), both derived from registered count (combinational decode, no extra latency).
- Routing (combinational on head flit, XY dimension-order): dx = dest X, dy = dest Y, unsigned compares.
  - dx > CUR_X -> E (001); dx < CUR_X -> W (010);
  - dx == CUR_X: dy > CUR_Y -> N (011); dy < CUR_Y -> S (100); dy == CUR_Y -> L (000).
  - empty -> 111 (matches no arbiter output code, so no select is set).
- `data_out` = head entry when !empty, else all zeros.
- Reset (async): pointers 0, count 0; hence `full`=0, `empty`=1, `request`=111, `data_out`=0. Buffer contents not reset. Reset mid-traffic discards all held flits immediately.

## Timing
- Flit written at edge k is visible on `data_out`/`request` after edge k (same cycle as count update); zero-cycle combinational path from head to `request`.
- Pop at edge k: next flit (or idle 111) appears after edge k.
- `grant` is level: each cycle it is high with !empty pops one flit; arbiter holding grant for N cycles drains up to N flits.
- Max throughput: one push and one pop per cycle.
- `full` deasserts the cycle after a pop from a full FIFO.

## Test plan
- Reset: assert `rst` mid-cycle with 3 flits stored -> immediately `empty`=1, `full`=0, `request`=111, `data_out`=0; after release, push works from entry 0.
- Routing (CUR_X=1, CUR_Y=1, ADDR_W=2): push dest (2,0),(0,3),(1,3),(1,0),(1,1), pop one per cycle -> `request` sequence 001, 010, 011, 100, 000, then 111.
- Fill/overflow (DEPTH=4): push 5 flits A..E, no grant -> `full`=1 after 4th, E dropped; 4 grants -> out A,B,C,D, `empty`=1.
- Simultaneous push/pop at count 2 -> count stays 2, order preserved; push+pop at full -> push rejected, count 3; pop+push at empty -> pop ignored, count 1.
- Wrap-around: 10 flits streamed with `grant` continuously high and one push per cycle -> all 10 emerge in order, 1-cycle latency each, count never exceeds 1.
- Grant while empty for 3 cycles -> pointers unchanged, `request`=111 throughout.
